// File: rtl/mem_lsu.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack bus, formats load data,
// stalls upstream while an access is outstanding and records misalign/timeout faults.
module mem_lsu #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_alu_c,
    input  logic [31:0] ex_rD2,
    input  logic [4:0]  ex_wR,
    input  logic        ex_rf_we,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] men_wD,
    output logic [4:0]  men_wR,
    output logic        men_rf_we,
    output logic        men_stall,
    output logic        men_misalign,
    output logic        men_bus_err,
    output logic [31:0] men_fault_addr
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]  state;
    logic [15:0] cnt;
    logic [4:0]  cap_wR;
    logic        cap_rf_we;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [1:0]  cap_lo;

    logic        mem_op;
    logic        misaligned;
    logic        timeout;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign mem_op = ex_valid & (ex_mem_rd | ex_mem_wr);

    always_comb begin
        misaligned = 1'b0;
        if (ex_size[1])
            misaligned = (ex_alu_c[1:0] != 2'b00);
        else if (ex_size[0])
            misaligned = ex_alu_c[0];
    end

    // The ack check takes priority wherever timeout is used, so ack on the last cycle completes.
    assign timeout = (({1'b0, cnt} + 17'd1) == 17'(TIMEOUT_CYC));

    always_comb begin
        if (ex_size[1]) begin
            be_next    = 4'b1111;
            wdata_next = ex_rD2;
        end else if (ex_size[0]) begin
            be_next    = 4'b0011 << ex_alu_c[1:0];
            wdata_next = {2{ex_rD2[15:0]}};
        end else begin
            be_next    = 4'b0001 << ex_alu_c[1:0];
            wdata_next = {4{ex_rD2[7:0]}};
        end
    end

    always_comb begin
        case (cap_lo)
            2'd0:    rd_byte = dm_rdata[7:0];
            2'd1:    rd_byte = dm_rdata[15:8];
            2'd2:    rd_byte = dm_rdata[23:16];
            default: rd_byte = dm_rdata[31:24];
        endcase
        rd_half = cap_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        if (cap_size[1])
            load_data = dm_rdata;
        else if (cap_size[0])
            load_data = {{16{rd_half[15] & ~cap_unsigned}}, rd_half};
        else
            load_data = {{24{rd_byte[7] & ~cap_unsigned}}, rd_byte};
    end

    always_comb begin
        men_wD    = ex_alu_c;
        men_wR    = ex_wR;
        men_rf_we = ex_valid & ex_rf_we;
        men_stall = 1'b0;
        if (state == IDLE) begin
            if (mem_op) begin
                men_rf_we = 1'b0;
                men_stall = ~misaligned;
            end
        end else begin
            men_wR = cap_wR;
            if (dm_ack) begin
                if (!dm_we) begin
                    men_wD    = load_data;
                    men_rf_we = cap_rf_we;
                end else begin
                    men_rf_we = 1'b0;
                end
            end else begin
                men_rf_we = 1'b0;
                men_stall = ~timeout;
            end
        end
        if (rst) begin
            men_stall = 1'b0;
            men_rf_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            dm_req         <= 1'b0;
            dm_we          <= 1'b0;
            dm_addr        <= '0;
            dm_be          <= '0;
            dm_wdata       <= '0;
            cap_wR         <= '0;
            cap_rf_we      <= 1'b0;
            cap_size       <= '0;
            cap_unsigned   <= 1'b0;
            cap_lo         <= '0;
            men_misalign   <= 1'b0;
            men_bus_err    <= 1'b0;
            men_fault_addr <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (mem_op) begin
                if (misaligned) begin
                    men_misalign <= 1'b1;
                    if (!men_misalign && !men_bus_err)
                        men_fault_addr <= ex_alu_c;
                end else begin
                    cap_wR       <= ex_wR;
                    cap_rf_we    <= ex_rf_we;
                    cap_size     <= ex_size;
                    cap_unsigned <= ex_unsigned;
                    cap_lo       <= ex_alu_c[1:0];
                    dm_req       <= 1'b1;
                    dm_we        <= ex_mem_wr;
                    dm_addr      <= {ex_alu_c[31:2], 2'b00};
                    dm_be        <= be_next;
                    dm_wdata     <= wdata_next;
                    state        <= BUSY;
                end
            end
        end else begin
            if (dm_ack) begin
                dm_req <= 1'b0;
                state  <= IDLE;
            end else if (timeout) begin
                dm_req      <= 1'b0;
                state       <= IDLE;
                men_bus_err <= 1'b1;
                if (!men_misalign && !men_bus_err)
                    men_fault_addr <= {dm_addr[31:2], cap_lo};
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the five-stage pipeline: sits between the EX/MEM register and the MEM/WB register. Issues loads and stores to data memory over a req/ack handshake with variable latency, aligns and sign/zero-extends load data, and stalls the upstream pipeline while an access is outstanding. Drives the `men_wD`/`men_wR`/`men_rf_we` inputs of the MEM/WB register. Flags misaligned accesses and bus timeouts in sticky status registers.

## Interface
- TIMEOUT_CYC, 255: maximum number of BUSY cycles without `dm_ack` before the access is aborted. Legal range 1..65535.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_mem_rd  in  1  instruction is a load
- ex_mem_wr  in  1  instruction is a store; wins if both rd and wr are set
- ex_size  in  2  access size: 00 byte, 01 half, 10 or 11 word
- ex_unsigned  in  1  zero-extend load data (LBU/LHU)
- ex_alu_c  in  32  ALU result: memory address for loads and stores, write data otherwise
- ex_rD2  in  32  store data
- ex_wR  in  5  destination register
- ex_rf_we  in  1  register-file write enable
- dm_req  out  1  memory request, registered
- dm_we  out  1  request is a write, registered
- dm_addr  out  32  word address `{addr[31:2],2'b00}`, registered
- dm_be  out  4  byte enables, registered
- dm_wdata  out  32  lane-replicated store data, registered
- dm_ack  in  1  memory completes the request this cycle; `dm_rdata` is valid in the same cycle
- dm_rdata  in  32  read word
- men_wD  out  32  write-back data
- men_wR  out  5  write-back register
- men_rf_we  out  1  write-back enable
- men_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- men_misalign  out  1  sticky misaligned-access flag
- men_bus_err  out  1  sticky timeout flag
- men_fault_addr  out  32  address of the first fault since reset

## Operation
- FSM states: IDLE and BUSY. Reset puts the block in IDLE.
- A memory op is `ex_valid & (ex_mem_rd | ex_mem_wr)`.
- An access is misaligned if it is a half access with `addr[0]=1`, or a word access with `addr[1:0]≠0`.

**IDLE**
- Non-memory op: `men_wD=ex_alu_c`, `men_wR=ex_wR`, `men_rf_we=ex_valid&ex_rf_we`, `men_stall=0`.
- Aligned memory op:
  - Capture wR, rf_we, size, unsigned and `addr[1:0]`.
  - Load the dm_* registers and set `dm_req<=1`.
  - Go to BUSY.
  - Same cycle: `men_stall=1`, `men_rf_we=0`.
- Misaligned memory op:
  - No request is issued; the instruction is dropped.
  - `men_rf_we=0`, `men_stall=0`.
  - Set `men_misalign<=1`.
  - Latch `men_fault_addr` only if both sticky flags are currently 0.

**BUSY**
- `dm_req` and the dm_* outputs hold until `dm_ack`. The wait counter increments every BUSY cycle.
- With `dm_ack=1`:
  - `men_stall=0`, `men_wR` = captured wR.
  - Load: `men_wD` = formatted `dm_rdata`, `men_rf_we` = captured rf_we.
  - Store: `men_rf_we=0`.
  - Next edge: `dm_req<=0`, return to IDLE.
- With `dm_ack=0`: `men_stall=1`, `men_rf_we=0`.
- When the counter reaches TIMEOUT_CYC without ack:
  - Abort: `dm_req<=0`, return to IDLE.
  - `men_rf_we=0`, `men_stall=0` in that cycle.
  - Set `men_bus_err<=1`; latch `men_fault_addr` under the same first-fault rule.

**Load formatting**
- Byte: lane `addr[1:0]`. Half: lane `addr[1]`. Word: `dm_rdata` unchanged.
- Sign-extend unless captured unsigned is set.

**Store encoding**
- Byte: `dm_wdata={4{rD2[7:0]}}`, `dm_be=4'b0001<<addr[1:0]`.
- Half: `dm_wdata={2{rD2[15:0]}}`, `dm_be=4'b0011<<addr[1:0]`.
- Word: `dm_wdata=rD2`, `dm_be=4'b1111`.
- For loads, `dm_be` follows the same pattern and `dm_we=0`.

## Timing
- Reset values: state IDLE, `dm_req=0`, `dm_we=0`, `dm_addr=0`, `dm_be=0`, `dm_wdata=0`, counter 0, `men_misalign=0`, `men_bus_err=0`, `men_fault_addr=0`.
- While `rst=1`, `men_stall=0` and `men_rf_we=0` are forced.
- Reset in BUSY aborts the access; `dm_req=0` from the following cycle.
- `dm_req` rises one cycle after the op is seen in IDLE.
- Minimum access occupies 2 cycles: issue, then BUSY with ack. The instruction behind it enters on the cycle after the ack.
- An ack arriving in the same cycle the counter hits TIMEOUT_CYC counts as completion, not timeout.
- `dm_ack` while IDLE is ignored.
- The `men_*` data outputs are combinational. MEN_WB latches them at the next edge.

## Test plan
- ALU passthrough: `ex_valid=1`, non-memory op, `alu_c=0x1234`, `wR=5`, `rf_we=1` → same-cycle `men_wD=0x1234`, `men_wR=5`, `men_rf_we=1`, `men_stall=0`.
- Load byte, ack after 3 BUSY cycles: `addr=0x103`, `rdata=0x80xxxxxx` → `dm_addr=0x100`, `dm_be=1000`, `men_wD=0xFFFFFF80`; same address with unsigned set → `0x00000080`. Stall is high for 3 cycles, then low in the ack cycle.
- Store half: `addr=0x22`, `rD2=0xABCD1234` → `dm_we=1`, `dm_be=1100`, `dm_wdata=0x12341234`, `men_rf_we=0` at ack.
- Misaligned word load at `0x41` → no `dm_req`, `men_misalign=1`, `fault_addr=0x41`. A later misalign at `0x83` leaves `fault_addr` at `0x41`.
- `TIMEOUT_CYC=4`, no ack → `dm_req` drops after 4 BUSY cycles, `men_bus_err=1`, `men_rf_we=0`. The next ALU op passes normally.
- Reset asserted in BUSY → `dm_req=0` and both flags 0 the next cycle. A late `dm_ack` afterwards has no effect.
